// File: rtl/bus_regbank_pkg.sv
// bus_regbank_pkg: shared defaults, write-counter width/saturation, select-width helper
package bus_regbank_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_REGS_DEF = 4;
  localparam int CNT_W = 8;
  localparam logic [0:CNT_W-1] CNT_MAX = '1;
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_regbank_if.sv
// bus_regbank_if: write bus, read handshake and status view; BUS_REGBANK_WRCNT_EN adds wr_cnt
interface bus_regbank_if
  import bus_regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
);
  localparam int SEL_W = sel_w(NUM_REGS);
  logic [0:DATA_W-1] data;
  logic [0:NUM_REGS-1] wr_en;
  logic clr;
  logic rd_req;
  logic [0:SEL_W-1] rd_sel;
  logic [0:DATA_W-1] rd_data;
  logic rd_valid;
  logic rd_err;
  logic [0:NUM_REGS*DATA_W-1] q;
  logic [0:NUM_REGS-1] dirty;
  logic [0:NUM_REGS-1] ovf;
`ifdef BUS_REGBANK_WRCNT_EN
  logic [0:NUM_REGS*CNT_W-1] wr_cnt;
  modport master (output data, wr_en, clr, rd_req, rd_sel,
                  input rd_data, rd_valid, rd_err, q, dirty, ovf, wr_cnt);
  modport slave (input data, wr_en, clr, rd_req, rd_sel,
                 output rd_data, rd_valid, rd_err, q, dirty, ovf, wr_cnt);
`else
  modport master (output data, wr_en, clr, rd_req, rd_sel,
                  input rd_data, rd_valid, rd_err, q, dirty, ovf);
  modport slave (input data, wr_en, clr, rd_req, rd_sel,
                 output rd_data, rd_valid, rd_err, q, dirty, ovf);
`endif
endinterface

// File: rtl/bus_regbank_slot.sv
// bus_regbank_slot: one register with dirty/overwrite flags; BUS_REGBANK_WRCNT_EN adds a saturating write counter
module bus_regbank_slot
  import bus_regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:DATA_W-1] i_data,
  input  logic              i_we,
  input  logic              i_clr,
  input  logic              i_rd,
  output logic [0:DATA_W-1] o_q,
  output logic              o_dirty,
`ifdef BUS_REGBANK_WRCNT_EN
  output logic [0:CNT_W-1]  o_cnt,
`endif
  output logic              o_ovf
);
  logic [0:DATA_W-1] r_q;
  logic r_dirty;
  logic r_ovf;
  // a write in the same cycle as a read of this slot keeps it dirty and is not an overwrite
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_q <= '0;
      r_dirty <= 1'b0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_q <= '0;
      r_dirty <= 1'b0;
      r_ovf <= 1'b0;
    end else if (i_we) begin
      r_q <= i_data;
      r_dirty <= 1'b1;
      if (r_dirty && !i_rd) r_ovf <= 1'b1;
    end else if (i_rd) begin
      r_dirty <= 1'b0;
    end
`ifdef BUS_REGBANK_WRCNT_EN
  logic [0:CNT_W-1] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_we && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
`endif
  assign o_q = r_q;
  assign o_dirty = r_dirty;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/bus_regbank.sv
// bus_regbank: broadcast-write register bank with registered read port; BUS_REGBANK_WRCNT_EN enables per-register write counters
module bus_regbank
  import bus_regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input logic clk,
  input logic reset,
  bus_regbank_if.slave bus
);
  logic [0:DATA_W-1] w_regs [NUM_REGS];
  logic w_in_range;
  logic w_rd_ok;
  logic [0:DATA_W-1] r_rd_data;
  logic r_rd_valid;
  logic r_rd_err;
  assign w_in_range = int'(bus.rd_sel) < NUM_REGS;
  assign w_rd_ok = bus.rd_req && w_in_range;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    bus_regbank_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_data  (bus.data),
      .i_we    (bus.wr_en[i]),
      .i_clr   (bus.clr),
      .i_rd    (w_rd_ok && int'(bus.rd_sel) == i),
      .o_q     (w_regs[i]),
      .o_dirty (bus.dirty[i]),
`ifdef BUS_REGBANK_WRCNT_EN
      .o_cnt   (bus.wr_cnt[i*CNT_W +: CNT_W]),
`endif
      .o_ovf   (bus.ovf[i])
    );
    assign bus.q[i*DATA_W +: DATA_W] = w_regs[i];
  end
  // read data is captured from pre-edge state, so clr or a write in the same cycle never affects it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_rd_data <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_err <= bus.rd_req && !w_in_range;
      if (w_rd_ok) r_rd_data <= w_regs[bus.rd_sel];
    end
  assign bus.rd_data = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err = r_rd_err;
endmodule

// File: doc/bus_regbank.md
Name: bus_regbank

Overview:
Parametrised broadcast-write register bank: one shared data bus, NUM_REGS registers, each loaded by its own write enable.
Adds a registered read port with a 1-cycle request/valid handshake, per-register dirty flags and sticky overwrite flags, and a synchronous clear.
Sits between the bus driver and downstream consumers; the consumer reads a register to acknowledge it.

Parameters:
DATA_W, 16, width of data bus and of each register
NUM_REGS, 4, number of registers (2..32)
SEL_W, $clog2(NUM_REGS) (min 1), read-select width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset; all state cleared while 0
data  in  DATA_W  shared write data bus
wr_en  in  NUM_REGS  per-register write enable; bit i loads register i
clr  in  1  synchronous clear of all registers and flags
rd_req  in  1  read request, sampled each cycle
rd_sel  in  SEL_W  register index for rd_req
rd_data  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_err  out  1  one-cycle pulse, rd_sel out of range
q  out  NUM_REGS*DATA_W  all register contents, register i at q[i*DATA_W +: DATA_W]
dirty  out  NUM_REGS  bit i set: register i written since last read/clear
ovf  out  NUM_REGS  bit i sticky: register i overwritten while dirty

Behaviour:
- Vectors indexed [0:W-1], index 0 is MSB.
- Reset (reset=0, async): registers, dirty, ovf, rd_data, rd_valid, rd_err all 0. Deassertion synchronous to clk; first write takes effect on first rising edge with reset=1.
- Write: on edge with wr_en[i]=1, reg[i] <= data, dirty[i] <= 1. Several wr_en bits may be set; all selected registers load the same data.
- Overwrite: wr_en[i]=1 while dirty[i]=1 and no read-clear of i that cycle -> ovf[i] <= 1. ovf clears only on clr or reset.
- Read: rd_req=1 at edge N -> at N+1 rd_valid=1, rd_data = reg[rd_sel] as held before edge N (old value if written same cycle). Read-clears dirty[rd_sel].
- rd_valid/rd_err are pulses; rd_data holds last value when rd_valid=0. Back-to-back requests allowed every cycle.
- Read and write same register same cycle: write wins for dirty (stays 1), no ovf set, rd_data returns old value.
- rd_sel >= NUM_REGS: rd_valid=0, rd_err=1 next cycle, rd_data unchanged, no flag changes.
- clr=1: all registers, dirty, ovf <= 0; overrides same-cycle writes. Same-cycle read still completes with the pre-clear value.
- q is a direct view of register state, no added latency.

Optional Feature:
BUS_REGBANK_WRCNT_EN: defined -> extra output wr_cnt (NUM_REGS*8); per-register 8-bit write counter, +1 per accepted write, saturates at 255, cleared by clr/reset, not by reads. Undefined -> port and counters absent; all other behaviour identical.

Decomposition:
- Package bus_regbank_pkg: default DATA_W/NUM_REGS constants, counter width (8), counter saturation value.
- One sub-module bus_regbank_slot: single register plus its dirty/ovf (and optional counter) logic, instantiated NUM_REGS times by generate.
- Read mux and handshake stay in the top.

Test Plan:
- Reset mid-operation: registers loaded with 16'hA5A5, reset=0 asynchronously between edges -> q, dirty, ovf, rd_valid all 0 immediately.
- Broadcast write: data=16'h0003, wr_en=4'b1010 -> registers 0 and 2 = 0003, 1 and 3 = 0, dirty=1010.
- Read handshake: reg2=16'h1234, rd_req=1, rd_sel=2 -> next cycle rd_valid=1, rd_data=1234, dirty[2]=0; rd_valid low the following cycle.
- Overwrite: write reg1=0005, then reg1=0006 without read -> ovf[1]=1, q reg1=0006; a later read does not clear ovf[1]; clr clears it.
- Collision: reg3=00FF, dirty[3]=1, same cycle wr_en[3]=1 data=0100 and read of 3 -> rd_data=00FF, reg3=0100, dirty[3]=1, ovf[3] unchanged.
- NUM_REGS=5, rd_sel=7 -> rd_err pulse, rd_valid=0; with BUS_REGBANK_WRCNT_EN, 300 writes to reg0 -> wr_cnt slot 0 = 255.
